// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: architectural PC with next-PC selection, boot/halt/trap sequencing and cycle/retire counters
//   iClk, iRst          clock, asynchronous active-high reset
//   iPCSrc, iJalr       taken branch/JAL, JALR (JALR wins)
//   iImmExt, iAluResult branch offset, JALR target (rs1+imm)
//   iStall              hold the PC this cycle
//   oPC, oPCPlus4       current PC and link value
//   oValid              oPC is a live instruction
//   oHalted, oTrap      self-loop halt, misaligned-target trap (both sticky until reset)
//   oTrapPC             offending target captured on trap
//   oCycleCount         cycles since reset release
//   oRetired            retired instructions
module pc_fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iPCSrc,
   input  logic        iJalr,
   input  logic [31:0] iImmExt,
   input  logic [31:0] iAluResult,
   input  logic        iStall,
   output logic [31:0] oPC,
   output logic [31:0] oPCPlus4,
   output logic        oValid,
   output logic        oHalted,
   output logic        oTrap,
   output logic [31:0] oTrapPC,
   output logic [31:0] oCycleCount,
   output logic [31:0] oRetired
);
   typedef enum logic [1:0] {BOOT, RUN, HALT, TRAP} state_t;
   state_t      state_q;
   logic [31:0] pc_q, trap_pc_q, cyc_q, ret_q;
   logic        valid_q, halted_q, trap_q;
   logic [31:0] target_d;
   logic        taken, misaligned, self_loop;
   always_comb begin
      target_d   = iJalr ? {iAluResult[31:1], 1'b0} : iPCSrc ? pc_q + iImmExt : pc_q + 32'd4;
      taken      = iJalr | iPCSrc;
      // JALR clears bit 0, so only bit 1 can flag a JALR target
      misaligned = taken & (target_d[1:0] != 2'b00);
      self_loop  = taken & (target_d == pc_q);
   end
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_VECTOR;
         trap_pc_q <= '0;
         cyc_q     <= '0;
         ret_q     <= '0;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         trap_q    <= 1'b0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         case (state_q)
            BOOT: begin
               state_q <= RUN;
               valid_q <= 1'b1;
            end
            RUN: if (!iStall) begin
               if (misaligned) begin
                  trap_pc_q <= target_d;
                  trap_q    <= 1'b1;
                  valid_q   <= 1'b0;
                  state_q   <= TRAP;
               end else begin
                  ret_q <= ret_q + 32'd1;
                  if (self_loop) begin
                     halted_q <= 1'b1;
                     valid_q  <= 1'b0;
                     state_q  <= HALT;
                  end else pc_q <= target_d;
               end
            end
            default: ;
         endcase
      end
   end
   assign oPC         = pc_q;
   assign oPCPlus4    = pc_q + 32'd4;
   assign oValid      = valid_q;
   assign oHalted     = halted_q;
   assign oTrap       = trap_q;
   assign oTrapPC     = trap_pc_q;
   assign oCycleCount = cyc_q;
   assign oRetired    = ret_q;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed scoreboard bench for pc_fetch_stage
module tb_pc_fetch_stage;
  typedef struct {
    int          at;
    string       name;
    int          sel;
    logic [31:0] v;
  } exp_t;
  exp_t        q[$];
  logic        iClk = 1'b0, iRst = 1'b1, iPCSrc = 1'b0, iJalr = 1'b0, iStall = 1'b0;
  logic [31:0] iImmExt = '0, iAluResult = '0;
  logic [31:0] oPC, oPCPlus4, oTrapPC, oCycleCount, oRetired;
  logic        oValid, oHalted, oTrap;
  int          ncyc = 0, n_vec = 0, n_miss = 0;
  localparam int PC = 0, P4 = 1, VAL = 2, HLT = 3, TRP = 4, TPC = 5, CYC = 6, RET = 7;
  always #5 iClk = ~iClk;
  pc_fetch_stage #(.RESET_VECTOR(32'h100)) dut (
    .iClk(iClk), .iRst(iRst), .iPCSrc(iPCSrc), .iJalr(iJalr), .iImmExt(iImmExt),
    .iAluResult(iAluResult), .iStall(iStall), .oPC(oPC), .oPCPlus4(oPCPlus4),
    .oValid(oValid), .oHalted(oHalted), .oTrap(oTrap), .oTrapPC(oTrapPC),
    .oCycleCount(oCycleCount), .oRetired(oRetired)
  );
  function automatic logic [31:0] pick(input int sel);
    case (sel)
      PC:      return oPC;
      P4:      return oPCPlus4;
      VAL:     return {31'd0, oValid};
      HLT:     return {31'd0, oHalted};
      TRP:     return {31'd0, oTrap};
      TPC:     return oTrapPC;
      CYC:     return oCycleCount;
      default: return oRetired;
    endcase
  endfunction
  initial begin : mon
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge iClk or posedge iRst);
      #1;
      ncyc++;
      while (q.size() > 0 && q[0].at <= ncyc) begin
        e = q.pop_front();
        a = pick(e.sel);
        n_vec++;
        if (a !== e.v) begin
          n_miss++;
          $display("FAIL %s: got %h expected %h", e.name, a, e.v);
        end
      end
    end
  end
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask
  task automatic ex(input string n, input int sel, input logic [31:0] v);
    q.push_back('{at: ncyc + 1, name: n, sel: sel, v: v});
  endtask
  task automatic br(input logic s, input logic j, input logic [31:0] imm, input logic [31:0] alu, input logic st);
    iPCSrc = s; iJalr = j; iImmExt = imm; iAluResult = alu; iStall = st;
  endtask
  task automatic do_reset();
    br(0, 0, 0, 0, 0);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask
  initial begin : drv
    tick();
    iRst = 1'b0;
    ex("rst_pc", PC, 32'h100); ex("rst_pc4", P4, 32'h104); ex("rst_valid", VAL, 0);
    ex("rst_halt", HLT, 0); ex("rst_trap", TRP, 0); ex("rst_tpc", TPC, 0);
    ex("rst_cyc", CYC, 0); ex("rst_ret", RET, 0);
    tick();
    ex("boot_valid", VAL, 1); ex("boot_pc0", PC, 32'h100);
    tick();
    ex("seq_pc1", PC, 32'h104); ex("seq_ret1", RET, 1);
    tick();
    ex("seq_pc2", PC, 32'h108); ex("seq_cyc3", CYC, 3);
    tick();
    ex("seq_ret3", RET, 3); ex("seq_cyc4", CYC, 4); ex("seq_pc3", PC, 32'h10C);
    br(0, 1, 0, 32'h21, 0);
    tick();
    ex("br_pc", PC, 32'h20); ex("br_pc4", P4, 32'h24); ex("br_ret_before", RET, 4);
    br(1, 0, 32'hFFFF_FFF0, 0, 0);
    tick();
    ex("br_target", PC, 32'h10); ex("br_ret_after", RET, 5);
    br(1, 1, 32'hFFFF_FFF0, 32'h205, 0);
    tick();
    ex("jalr_pc", PC, 32'h204); ex("jalr_notrap", TRP, 0); ex("jalr_valid", VAL, 1);
    br(0, 1, 0, 32'h3C, 0);
    tick();
    br(0, 0, 0, 0, 0);
    ex("mid_pc", PC, 32'h3C); ex("mid_cyc", CYC, 8);
    #6;
    ex("arst_pc", PC, 32'h100); ex("arst_pc4", P4, 32'h104); ex("arst_valid", VAL, 0);
    ex("arst_cyc", CYC, 0); ex("arst_ret", RET, 0);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    tick();
    br(0, 1, 0, 32'h40, 0);
    tick();
    ex("mis_pc", PC, 32'h40); ex("mis_ret_before", RET, 1);
    br(1, 0, 32'h2, 0, 0);
    tick();
    if (oTrap !== 1'b1 || oTrapPC !== 32'h42) begin
      n_miss++;
      $display("FAIL mis_direct: trap %b tpc %h", oTrap, oTrapPC);
    end
    ex("mis_trap", TRP, 1); ex("mis_tpc", TPC, 32'h42); ex("mis_pc_hold", PC, 32'h40);
    ex("mis_valid", VAL, 0); ex("mis_ret", RET, 1);
    br(1, 0, 32'h100, 0, 0);
    tick();
    ex("trap_frozen_pc", PC, 32'h40); ex("trap_frozen_tpc", TPC, 32'h42); ex("trap_sticky", TRP, 1);
    tick();
    do_reset();
    ex("boot2_valid", VAL, 0); ex("boot2_cyc", CYC, 0);
    br(1, 0, 32'h40, 0, 0);
    tick();
    ex("boot_ignore", PC, 32'h100);
    br(0, 1, 0, 32'h80, 0);
    tick();
    ex("sl_pc", PC, 32'h80); ex("sl_ret0", RET, 1);
    br(1, 0, 0, 0, 1);
    tick();
    ex("stall1_pc", PC, 32'h80); ex("stall1_halt", HLT, 0); ex("stall1_ret", RET, 1);
    tick();
    ex("stall2_pc", PC, 32'h80); ex("stall2_halt", HLT, 0); ex("stall2_ret", RET, 1);
    ex("stall2_valid", VAL, 1);
    iStall = 1'b0;
    tick();
    if (oHalted !== 1'b1 || oPC !== 32'h80) begin
      n_miss++;
      $display("FAIL halt_direct: halted %b pc %h", oHalted, oPC);
    end
    ex("halt", HLT, 1); ex("halt_pc", PC, 32'h80); ex("halt_ret", RET, 2);
    ex("halt_valid", VAL, 0); ex("halt_cyc", CYC, 5);
    br(0, 1, 0, 32'h200, 0);
    tick();
    ex("halt_cyc_inc", CYC, 6); ex("halt_frozen", PC, 32'h80); ex("halt_sticky", HLT, 1);
    tick();
    do_reset();
    tick();
    br(0, 1, 0, 32'hFFFF_FFFC, 0);
    tick();
    ex("wrap_pc", PC, 32'hFFFF_FFFC); ex("wrap_pc4", P4, 32'h0);
    br(0, 0, 0, 0, 0);
    tick();
    if (oPC !== 32'h0 || oValid !== 1'b1) begin
      n_miss++;
      $display("FAIL wrap_direct: pc %h valid %b", oPC, oValid);
    end
    ex("wrap_next", PC, 32'h0); ex("wrap_valid", VAL, 1);
    br(0, 1, 0, 32'h7, 0);
    tick();
    if (oTrap !== 1'b1 || oTrapPC !== 32'h6) begin
      n_miss++;
      $display("FAIL jalr_mis_direct: trap %b tpc %h", oTrap, oTrapPC);
    end
    ex("jalr_mis_trap", TRP, 1); ex("jalr_mis_tpc", TPC, 32'h6); ex("jalr_mis_pc", PC, 32'h0);
    br(0, 0, 0, 0, 0);
    tick();
    repeat (5) if (q.size() > 0) tick();
    while (q.size() > 0) begin
      n_miss++;
      $display("FAIL %s: never sampled, expected %h", q[0].name, q[0].v);
      void'(q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Program-counter and fetch-sequencing stage that sits directly upstream of the control unit. It owns the architectural PC register and drives the PC into the instruction ROM/control path each cycle. It computes the next PC from the control unit's branch decision (`oPCSrc`/`oImmExt`) or from a JALR target, and supplies PC+4 for link writeback. It also sequences boot, stall, halt-on-self-loop and misaligned-target trap, and keeps cycle and retired-instruction counters.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `iClk`  in  1  clock; all state updates on the rising edge.
- `iRst`  in  1  asynchronous, active-high reset.
- `iPCSrc`  in  1  taken branch/JAL from the control unit.
- `iJalr`  in  1  current instruction is JALR; takes priority over `iPCSrc`.
- `iImmExt`  in  32  sign-extended immediate from the control unit.
- `iAluResult`  in  32  rs1+imm for JALR.
- `iStall`  in  1  hold the PC this cycle.
- `oPC`  out  32  current PC, fed to the control unit `iPC`.
- `oPCPlus4`  out  32  oPC+4, for link writeback.
- `oValid`  out  1  oPC holds a live instruction this cycle.
- `oHalted`  out  1  self-loop detected; fetch frozen.
- `oTrap`  out  1  misaligned target detected; fetch frozen.
- `oTrapPC`  out  32  offending target address captured on trap.
- `oCycleCount`  out  32  cycles since reset deassertion.
- `oRetired`  out  32  instructions retired.

## Operation
- Target selection (combinational):
  - If `iJalr`: target = {iAluResult[31:1],1'b0}.
  - Else if `iPCSrc`: target = oPC + iImmExt.
  - Else: target = oPC + 4.
  - Taken = `iJalr` | `iPCSrc`.
- All additions are 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- Misaligned: taken & target[1:0] != 0. JALR bit 0 is already cleared, so only bit 1 can trigger it.
- Self-loop: taken & target == oPC.
- FSM states are BOOT, RUN, HALT and TRAP.
  - BOOT: oValid=0, PC holds RESET_VECTOR. Always → RUN next cycle, giving one bubble for the ROM to settle.
  - RUN, oValid=1. Priority order per cycle:
    - `iStall`: PC holds, oRetired unchanged, no trap or halt check.
    - Misaligned: PC holds, oTrapPC←target, → TRAP, instruction not retired.
    - Self-loop: PC holds, oRetired+1, → HALT.
    - Otherwise: PC←target, oRetired+1.
  - HALT: oValid=0, oHalted=1, PC frozen. Exit only via reset.
  - TRAP: oValid=0, oTrap=1, PC and oTrapPC frozen. Exit only via reset.
- oCycleCount increments every edge while `iRst` is low, in every state, and wraps at 2^32.
- oRetired wraps at 2^32.
- Inputs are ignored in BOOT, HALT and TRAP.

## Timing
- Reset values (asynchronous, immediate on `iRst` high):
  - state=BOOT, oPC=RESET_VECTOR, oPCPlus4=RESET_VECTOR+4.
  - oValid=0, oHalted=0, oTrap=0, oTrapPC=0, oCycleCount=0, oRetired=0.
- Reset asserted mid-operation overrides everything in the same instant; no partial update is permitted.
- First live fetch is on the second rising edge after reset deassertion (BOOT→RUN), with oPC=RESET_VECTOR.
- Next-PC latency is one cycle: the decision in cycle n appears on oPC in cycle n+1. Branches carry no bubble.
- oHalted and oTrap assert in the cycle after detection and stay registered, never combinational.
- `iStall` is sampled at the edge; a stall held N cycles holds oPC for N+1 visible cycles including the current one.

## Test plan
- **Reset/boot:** RESET_VECTOR=32'h100, release reset, no branches.
  - oValid=0 for 1 cycle, then oPC sequence 0x100, 0x104, 0x108.
  - oRetired=3 after 3 RUN cycles; oCycleCount=4.
- **Branch:** oPC=0x20, iPCSrc=1, iImmExt=32'hFFFF_FFF0.
  - Next oPC=0x10, oRetired+1, oPCPlus4 during the branch cycle = 0x24.
- **JALR:** iJalr=1 with iPCSrc=1, iAluResult=32'h0000_0205.
  - Next oPC=0x204, since JALR wins and bit 0 is cleared, with no trap.
- **Misaligned:** oPC=0x40, iPCSrc=1, iImmExt=2.
  - Next cycle: oTrap=1, oTrapPC=0x42, oPC=0x40, oValid=0, oRetired unchanged.
  - Further branches are ignored until reset.
- **Self-loop and stall:** oPC=0x80 with iStall=1 and iPCSrc=1, iImmExt=0 for 2 cycles.
  - oPC stays at 0x80, no halt, oRetired unchanged.
  - Drop iStall: next cycle oHalted=1, oPC=0x80, oRetired+1, oCycleCount still incrementing.
- **Reset mid-run and wrap:** assert iRst asynchronously between edges while oPC=0x3C.
  - All outputs take reset values immediately.
  - Separately, oPC=32'hFFFF_FFFC with no branch gives next oPC=0, oValid=1.
